// File: rtl/params_out_buffer.sv
// Readback responder for the glitch-parameter register bank: answers config reads
// with a registered word and valid/ack handshake, and owns the glitch counter and sticky status.
module params_out_buffer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        config_enable,
    input  logic [7:0]  cmd,
    input  logic [15:0] addr,
    input  logic [15:0] glitch_width,
    input  logic [15:0] glitch_period,
    input  logic [15:0] glitch_pos,
    input  logic [15:0] glitch_pos_fine,
    input  logic        glitch_en,
    input  logic        glitch_fire,
    output logic [15:0] data_read,
    output logic        data_valid,
    input  logic        data_ack,
    output logic        busy
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned TO_W   = 16;

    localparam logic [7:0] CMD_CONFIG_READ  = 8'h02;
    localparam logic [7:0] CMD_CONFIG_WRITE = 8'h03;

    localparam logic [ADDR_W-1:0] ADDR_WIDTH    = 16'h0000;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 16'h0001;
    localparam logic [ADDR_W-1:0] ADDR_POS      = 16'h0002;
    localparam logic [ADDR_W-1:0] ADDR_POS_FINE = 16'h0003;
    localparam logic [ADDR_W-1:0] ADDR_ENABLE   = 16'h0004;
    localparam logic [ADDR_W-1:0] ADDR_COUNT    = 16'h0005;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 16'h0006;

    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    logic [TO_W-1:0]     tcnt_q;
    logic [TO_W-1:0]     tcnt_d;
    logic [DATA_W-1:0]   data_read_d;
    logic                data_valid_d;
    logic                busy_d;

    logic [CNT_W-1:0]    glitch_count_q;
    logic                sat_q;
    logic                bad_addr_q;
    logic                timeout_q;
    logic                overrun_q;

    logic                rd_req;
    logic                wr_clr;
    logic                fire_ok;
    logic                overrun_set;
    logic                timeout_set;
    logic                bad_set;
    logic                status_rd;
    logic                lookup_bad;
    logic [DATA_W-1:0]   lookup_word;
    logic [DATA_W-1:0]   status_word;

    assign rd_req      = config_enable && (cmd == CMD_CONFIG_READ);
    assign wr_clr      = config_enable && (cmd == CMD_CONFIG_WRITE) && (addr == ADDR_COUNT);
    assign fire_ok     = glitch_fire && glitch_en;
    assign overrun_set = rd_req && (state_q != IDLE);
    assign status_word = {11'b0, sat_q, bad_addr_q, timeout_q, overrun_q, glitch_en};

    // Register-map read mux, evaluated against live inputs during LOOKUP
    always_comb begin
        lookup_word = '0;
        lookup_bad  = 1'b0;
        case (addr_q)
            ADDR_WIDTH:    lookup_word = glitch_width;
            ADDR_PERIOD:   lookup_word = glitch_period;
            ADDR_POS:      lookup_word = glitch_pos;
            ADDR_POS_FINE: lookup_word = glitch_pos_fine;
            ADDR_ENABLE:   lookup_word = {15'b0, glitch_en};
            ADDR_COUNT:    lookup_word = DATA_W'(glitch_count_q);
            ADDR_STATUS:   lookup_word = status_word;
            default:       lookup_bad  = 1'b1;
        endcase
    end

    // Next-state and registered-output values
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        tcnt_d       = tcnt_q;
        data_read_d  = data_read;
        data_valid_d = data_valid;
        timeout_set  = 1'b0;
        bad_set      = 1'b0;
        status_rd    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    addr_d  = addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                data_read_d  = lookup_word;
                data_valid_d = 1'b1;
                bad_set      = lookup_bad;
                status_rd    = (addr_q == ADDR_STATUS);
                tcnt_d       = '0;
                state_d      = RESP;
            end
            RESP: begin
                if (data_ack) begin
                    data_valid_d = 1'b0;
                    tcnt_d       = '0;
                    state_d      = IDLE;
                end else if (tcnt_q == TO_LAST) begin
                    // Consumer never answered: abandon the response
                    timeout_set  = 1'b1;
                    data_valid_d = 1'b0;
                    tcnt_d       = '0;
                    state_d      = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            default: begin
                data_valid_d = 1'b0;
                tcnt_d       = '0;
                state_d      = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            tcnt_q     <= '0;
            data_read  <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tcnt_q     <= tcnt_d;
            data_read  <= data_read_d;
            data_valid <= data_valid_d;
            busy       <= busy_d;
        end
    end

    // Sticky flags: a status read clears them, but a coincident set event wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            bad_addr_q <= 1'b0;
        end else begin
            overrun_q  <= (overrun_q  && !status_rd) || overrun_set;
            timeout_q  <= (timeout_q  && !status_rd) || timeout_set;
            bad_addr_q <= (bad_addr_q && !status_rd) || bad_set;
        end
    end

    // Saturating glitch counter; the clearing write has priority over a fire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_count_q <= '0;
            sat_q          <= 1'b0;
        end else if (wr_clr) begin
            glitch_count_q <= '0;
            sat_q          <= 1'b0;
        end else if (fire_ok) begin
            if (glitch_count_q != CNT_MAX) begin
                glitch_count_q <= glitch_count_q + CNT_W'(1);
            end
            if ((glitch_count_q == CNT_MAX) || (glitch_count_q == CNT_MAX - CNT_W'(1))) begin
                sat_q <= 1'b1;
            end
        end
    end

endmodule
